// File: rtl/mem_cmd_tracker.sv
// Passive DDR3 command-bus tracker.
// Decodes one command per cycle, tracks per-rank/per-bank open state and
// elapsed-cycle timers, raises sticky protocol/timing errors and keeps
// saturating per-command counters.
module mem_cmd_tracker #(
  parameter  int MEM_RANKS  = 1,
  parameter  int BA_WIDTH   = 3,
  parameter  int ADDR_WIDTH = 16,
  parameter  int T_RCD      = 11,
  parameter  int T_RP       = 11,
  parameter  int T_RAS      = 28,
  parameter  int CNT_WIDTH  = 32,
  localparam int RW         = (MEM_RANKS > 1) ? $clog2(MEM_RANKS) : 1,
  localparam int NB         = 2 ** BA_WIDTH,
  localparam int NBT        = MEM_RANKS * NB
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mon_en,
  input  logic [MEM_RANKS-1:0]  cs_n,
  input  logic [MEM_RANKS-1:0]  clk_en,
  input  logic                  ras_n,
  input  logic                  cas_n,
  input  logic                  we_n,
  input  logic [BA_WIDTH-1:0]   ba,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  err_clr,
  output logic                  cmd_valid,
  output logic [2:0]            cmd_code,
  output logic [RW-1:0]         cmd_rank,
  output logic [BA_WIDTH-1:0]   cmd_bank,
  output logic [NBT-1:0]        open_mask,
  output logic [6:0]            err,
  output logic [CNT_WIDTH-1:0]  act_cnt,
  output logic [CNT_WIDTH-1:0]  rd_cnt,
  output logic [CNT_WIDTH-1:0]  wr_cnt,
  output logic [CNT_WIDTH-1:0]  pre_cnt,
  output logic [CNT_WIDTH-1:0]  ref_cnt
);

  localparam int TMAX_A = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int TMAX   = (TMAX_A > T_RAS) ? TMAX_A : T_RAS;
  localparam int TW     = $clog2(TMAX + 1);
  localparam logic [TW-1:0] TSAT = TW'(TMAX);

  localparam logic [2:0] CMD_MRS = 3'b000;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_ZQ  = 3'b110;
  localparam logic [2:0] CMD_NOP = 3'b111;

  localparam int E_MULTI = 0;
  localparam int E_ACT   = 1;
  localparam int E_RWCL  = 2;
  localparam int E_TRCD  = 3;
  localparam int E_TRAS  = 4;
  localparam int E_TRP   = 5;
  localparam int E_REF   = 6;

  logic [2:0]     pins;
  logic           a10;
  logic           unused_addr;
  logic           sel_seen;
  logic           sel_multi;
  logic           sel_cke;
  logic [RW-1:0]  sel_rank;
  logic           cmd_ok;
  logic [6:0]     err_set;
  logic [NBT-1:0] open_q;
  logic [NBT-1:0] open_d;
  logic [NBT-1:0] tmr_load;
  logic [TW-1:0]  tmr_q [NBT];
  logic           inc_act, inc_rd, inc_wr, inc_pre, inc_ref;

  assign pins        = {ras_n, cas_n, we_n};
  assign a10         = addr[10];
  assign unused_addr = ^addr;
  assign open_mask   = open_q;

  // Find the selected rank and detect more than one chip select low.
  always_comb begin
    sel_seen  = 1'b0;
    sel_multi = 1'b0;
    sel_cke   = 1'b0;
    sel_rank  = '0;
    for (int unsigned r = 0; r < MEM_RANKS; r++) begin
      if (!cs_n[r]) begin
        if (sel_seen) sel_multi = 1'b1;
        sel_seen = 1'b1;
        sel_rank = RW'(r);
        sel_cke  = clk_en[r];
      end
    end
    cmd_ok = mon_en && sel_seen && !sel_multi && sel_cke && (pins != CMD_NOP);
    inc_act = cmd_ok && (pins == CMD_ACT);
    inc_rd  = cmd_ok && (pins == CMD_RD);
    inc_wr  = cmd_ok && (pins == CMD_WR);
    inc_pre = cmd_ok && (pins == CMD_PRE);
    inc_ref = cmd_ok && (pins == CMD_REF);
  end

  // Per-bank next state, timer reloads and new violations for this cycle.
  always_comb begin
    open_d   = open_q;
    tmr_load = '0;
    err_set  = '0;
    err_set[E_MULTI] = mon_en && sel_multi;
    for (int unsigned r = 0; r < MEM_RANKS; r++) begin
      for (int unsigned b = 0; b < NB; b++) begin
        int unsigned idx;
        logic        in_rank;
        logic        hit;
        int          k;
        idx     = r * NB + b;
        in_rank = cmd_ok && (sel_rank == RW'(r));
        hit     = in_rank && (ba == BA_WIDTH'(b));
        k       = int'(tmr_q[idx]);
        case (pins)
          CMD_ACT: begin
            if (hit) begin
              if (open_q[idx]) begin
                err_set[E_ACT] = 1'b1;
                tmr_load[idx]  = 1'b1;
              end else if (k < T_RP) begin
                err_set[E_TRP] = 1'b1;
              end else begin
                open_d[idx]   = 1'b1;
                tmr_load[idx] = 1'b1;
              end
            end
          end
          CMD_RD, CMD_WR: begin
            if (hit) begin
              if (!open_q[idx]) begin
                err_set[E_RWCL] = 1'b1;
              end else begin
                if (k < T_RCD) err_set[E_TRCD] = 1'b1;
                if (a10) begin
                  open_d[idx]   = 1'b0;
                  tmr_load[idx] = 1'b1;
                end
              end
            end
          end
          CMD_PRE: begin
            // A10 widens the match to every bank of the selected rank.
            if (in_rank && (a10 || (ba == BA_WIDTH'(b))) && open_q[idx]) begin
              if (k < T_RAS) err_set[E_TRAS] = 1'b1;
              open_d[idx]   = 1'b0;
              tmr_load[idx] = 1'b1;
            end
          end
          CMD_REF: begin
            if (in_rank && open_q[idx]) err_set[E_REF] = 1'b1;
          end
          CMD_MRS, CMD_ZQ, CMD_NOP: ;
          default: ;
        endcase
      end
    end
  end

  // Bank state and elapsed-cycle timers; a reloaded timer reads 1 in the
  // following cycle so its value always equals cycles since the load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_q <= '0;
      for (int unsigned i = 0; i < NBT; i++) tmr_q[i] <= TSAT;
    end else begin
      open_q <= open_d;
      for (int unsigned i = 0; i < NBT; i++) begin
        if (tmr_load[i])         tmr_q[i] <= TW'(1);
        else if (tmr_q[i] != TSAT) tmr_q[i] <= tmr_q[i] + TW'(1);
      end
    end
  end

  // Registered decoded-command stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid <= 1'b0;
      cmd_code  <= '0;
      cmd_rank  <= '0;
      cmd_bank  <= '0;
    end else begin
      cmd_valid <= cmd_ok;
      if (cmd_ok) begin
        cmd_code <= pins;
        cmd_rank <= sel_rank;
        cmd_bank <= ba;
      end
    end
  end

  // Sticky errors; a clear still lets this cycle's new violations through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= '0;
    else        err <= (err_clr ? 7'd0 : err) | err_set;
  end

  // Saturating command counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_cnt <= '0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      pre_cnt <= '0;
      ref_cnt <= '0;
    end else begin
      if (inc_act && (act_cnt != '1)) act_cnt <= act_cnt + 1'b1;
      if (inc_rd  && (rd_cnt  != '1)) rd_cnt  <= rd_cnt  + 1'b1;
      if (inc_wr  && (wr_cnt  != '1)) wr_cnt  <= wr_cnt  + 1'b1;
      if (inc_pre && (pre_cnt != '1)) pre_cnt <= pre_cnt + 1'b1;
      if (inc_ref && (ref_cnt != '1)) ref_cnt <= ref_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_cmd_tracker.sv
// Directed bench for mem_cmd_tracker: two ranks, 4-bit counters.
module tb_mem_cmd_tracker;

  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_RD  = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mon_en;
  logic [1:0]  cs_n;
  logic [1:0]  clk_en;
  logic        ras_n, cas_n, we_n;
  logic [2:0]  ba;
  logic [15:0] addr;
  logic        err_clr;
  logic        cmd_valid;
  logic [2:0]  cmd_code;
  logic [0:0]  cmd_rank;
  logic [2:0]  cmd_bank;
  logic [15:0] open_mask;
  logic [6:0]  err;
  logic [3:0]  act_cnt, rd_cnt, wr_cnt, pre_cnt, ref_cnt;

  int n_vec = 0;
  int n_err = 0;

  mem_cmd_tracker #(
    .MEM_RANKS (2),
    .BA_WIDTH  (3),
    .ADDR_WIDTH(16),
    .T_RCD     (11),
    .T_RP      (11),
    .T_RAS     (28),
    .CNT_WIDTH (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mon_en   (mon_en),
    .cs_n     (cs_n),
    .clk_en   (clk_en),
    .ras_n    (ras_n),
    .cas_n    (cas_n),
    .we_n     (we_n),
    .ba       (ba),
    .addr     (addr),
    .err_clr  (err_clr),
    .cmd_valid(cmd_valid),
    .cmd_code (cmd_code),
    .cmd_rank (cmd_rank),
    .cmd_bank (cmd_bank),
    .open_mask(open_mask),
    .err      (err),
    .act_cnt  (act_cnt),
    .rd_cnt   (rd_cnt),
    .wr_cnt   (wr_cnt),
    .pre_cnt  (pre_cnt),
    .ref_cnt  (ref_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    mon_en  = 1'b1;
    cs_n    = 2'b11;
    clk_en  = 2'b11;
    {ras_n, cas_n, we_n} = 3'b111;
    ba      = '0;
    addr    = '0;
    err_clr = 1'b0;
  endtask

  task automatic nops(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One command cycle; outputs are sampled 1 time unit after the edge ending it.
  task automatic issue(input int r, input logic [2:0] code, input logic [2:0] b, input logic ap);
    cs_n    = 2'b11;
    cs_n[r] = 1'b0;
    {ras_n, cas_n, we_n} = code;
    ba       = b;
    addr     = '0;
    addr[10] = ap;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    nops(2);
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    do_reset();
    chk("rst_err", 32'(err), 0);
    chk("rst_open", 32'(open_mask), 0);
    chk("rst_valid", 32'(cmd_valid), 0);
    chk("rst_act", 32'(act_cnt), 0);

    // Legal ACT/RD/PRE/ACT sequence at exact timing boundaries.
    issue(0, C_ACT, 3'd2, 1'b0);                       // cycle 0
    chk("g1_valid", 32'(cmd_valid), 1);
    chk("g1_code", 32'(cmd_code), 3);
    chk("g1_bank", 32'(cmd_bank), 2);
    chk("g1_rank", 32'(cmd_rank), 0);
    chk("g1_open_act", 32'(open_mask), 16'h0004);
    nops(10);
    chk("g1_strobe", 32'(cmd_valid), 0);
    issue(0, C_RD, 3'd2, 1'b0);                        // cycle 11
    chk("g1_err_rd", 32'(err), 0);
    nops(16);
    issue(0, C_PRE, 3'd2, 1'b0);                       // cycle 28
    chk("g1_open_pre", 32'(open_mask), 0);
    nops(10);
    issue(0, C_ACT, 3'd2, 1'b0);                       // cycle 39
    chk("g1_err", 32'(err), 0);
    chk("g1_open_act2", 32'(open_mask), 16'h0004);
    chk("g1_act_cnt", 32'(act_cnt), 2);
    chk("g1_rd_cnt", 32'(rd_cnt), 1);
    chk("g1_pre_cnt", 32'(pre_cnt), 1);

    // tRCD violation, then clear.
    do_reset();
    issue(0, C_ACT, 3'd0, 1'b0);                       // cycle 0
    nops(9);
    issue(0, C_WR, 3'd0, 1'b0);                        // cycle 10
    chk("g2_trcd", 32'(err), 7'h08);
    chk("g2_wr_cnt", 32'(wr_cnt), 1);
    chk("g2_open", 32'(open_mask), 16'h0001);
    err_clr = 1'b1;
    nops(1);
    err_clr = 1'b0;
    chk("g2_clr", 32'(err), 0);

    // tRAS then tRP violation.
    do_reset();
    issue(0, C_ACT, 3'd1, 1'b0);                       // cycle 0
    nops(26);
    issue(0, C_PRE, 3'd1, 1'b0);                       // cycle 27
    chk("g3_tras", 32'(err), 7'h10);
    chk("g3_open", 32'(open_mask), 0);
    nops(9);
    issue(0, C_ACT, 3'd1, 1'b0);                       // cycle 37
    chk("g3_trp", 32'(err), 7'h30);

    // Two ranks, same bank number, REF/PRE-all/auto-precharge.
    do_reset();
    issue(0, C_ACT, 3'd3, 1'b0);                       // cycle 0
    issue(1, C_ACT, 3'd3, 1'b0);                       // cycle 1
    chk("g4_rank1", 32'(cmd_rank), 1);
    issue(1, C_REF, 3'd0, 1'b0);                       // cycle 2
    chk("g4_ref_open", 32'(err), 7'h40);
    chk("g4_open2", 32'(open_mask), 16'h0808);
    chk("g4_ref_cnt", 32'(ref_cnt), 1);
    nops(26);
    issue(1, C_PRE, 3'd0, 1'b1);                       // cycle 29
    chk("g4_preall", 32'(open_mask), 16'h0008);
    chk("g4_err_hold", 32'(err), 7'h40);
    chk("g4_pre_cnt", 32'(pre_cnt), 1);
    issue(0, C_RD, 3'd3, 1'b1);                        // cycle 30
    chk("g4_ap_open", 32'(open_mask), 0);
    chk("g4_ap_pre_cnt", 32'(pre_cnt), 1);
    chk("g4_rd_cnt", 32'(rd_cnt), 1);

    // Multi-CS, RD to idle bank, ACT to open bank, mon_en=0, clear+new.
    do_reset();
    cs_n = 2'b00;
    {ras_n, cas_n, we_n} = C_ACT;
    nops(1);
    idle();
    chk("g5_multi", 32'(err), 7'h01);
    chk("g5_multi_valid", 32'(cmd_valid), 0);
    chk("g5_multi_cnt", 32'(act_cnt), 0);
    issue(0, C_RD, 3'd5, 1'b0);
    chk("g5_rw_closed", 32'(err), 7'h05);
    issue(0, C_ACT, 3'd6, 1'b0);
    issue(0, C_ACT, 3'd6, 1'b0);
    chk("g5_act_open", 32'(err), 7'h07);
    chk("g5_act_cnt", 32'(act_cnt), 2);
    chk("g5_open", 32'(open_mask), 16'h0040);
    mon_en = 1'b0;
    issue(0, C_ACT, 3'd7, 1'b0);
    chk("g5_mon_cnt", 32'(act_cnt), 2);
    chk("g5_mon_valid", 32'(cmd_valid), 0);
    chk("g5_mon_open", 32'(open_mask), 16'h0040);
    err_clr = 1'b1;
    issue(1, C_RD, 3'd7, 1'b0);
    chk("g5_clr_new", 32'(err), 7'h04);

    // Counter saturation, async reset mid-run, clean ACT after release.
    do_reset();
    repeat (17) issue(0, C_REF, 3'd0, 1'b0);
    chk("g6_ref_sat", 32'(ref_cnt), 15);
    chk("g6_ref_err", 32'(err), 0);
    issue(0, C_ACT, 3'd4, 1'b0);
    chk("g6_open", 32'(open_mask), 16'h0010);
    #2 rst_n = 1'b0;
    #1;
    chk("g6_ar_open", 32'(open_mask), 0);
    chk("g6_ar_ref", 32'(ref_cnt), 0);
    chk("g6_ar_act", 32'(act_cnt), 0);
    chk("g6_ar_valid", 32'(cmd_valid), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(0, C_ACT, 3'd4, 1'b0);
    chk("g6_post_err", 32'(err), 0);
    chk("g6_post_open", 32'(open_mask), 16'h0010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
